// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer that drives one external combinational 8-bit ALU to
// run an 8x8 shift-add multiply or a 16-bit add built from two chained byte adds.
module alu_seq_ctrl #(
  parameter bit CLR_ON_START = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        carry,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_sel,
  output logic        alu_cin,
  input  logic [7:0]  alu_out,
  input  logic        alu_cout
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SHR = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_M_ADD = 3'd1,
    S_M_SHR = 3'd2,
    S_A_LO  = 3'd3,
    S_A_HI  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [15:0] opa_r, opb_r;
  logic [7:0]  hi_r, lo_r;
  logic        cf_r;
  logic [2:0]  iter_r;
  logic [15:0] result_r;
  logic        carry_r, busy_r, done_r;
  logic [7:0]  alu_a_s, alu_b_s;
  logic [2:0]  alu_sel_s;
  logic        alu_cin_s;

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s = op ? S_A_LO : S_M_ADD;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_M_ADD: state_nxt_s = S_M_SHR;
      S_M_SHR: begin
        if (iter_r == 3'd7) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_M_ADD;
        end
      end
      S_A_LO:  state_nxt_s = S_A_HI;
      S_A_HI:  state_nxt_s = S_DONE;
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // ALU operand/operation drive; IDLE and DONE present an all-zero add
  always_comb begin
    alu_a_s   = 8'h00;
    alu_b_s   = 8'h00;
    alu_sel_s = ALU_ADD;
    alu_cin_s = 1'b0;
    case (state_r)
      S_M_ADD: begin
        alu_a_s = hi_r;
        alu_b_s = lo_r[0] ? opa_r[7:0] : 8'h00;
      end
      S_M_SHR: begin
        alu_a_s   = hi_r;
        alu_sel_s = ALU_SHR;
      end
      S_A_LO: begin
        alu_a_s = opa_r[7:0];
        alu_b_s = opb_r[7:0];
      end
      S_A_HI: begin
        alu_a_s   = opa_r[15:8];
        alu_b_s   = opb_r[15:8];
        alu_cin_s = cf_r;
      end
      default: begin
        alu_a_s = 8'h00;
      end
    endcase
  end

  // State register, datapath registers and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      opa_r    <= 16'h0000;
      opb_r    <= 16'h0000;
      hi_r     <= 8'h00;
      lo_r     <= 8'h00;
      cf_r     <= 1'b0;
      iter_r   <= 3'd0;
      result_r <= 16'h0000;
      carry_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != S_IDLE);
      done_r  <= (state_nxt_s == S_DONE);
      case (state_r)
        S_IDLE: begin
          if (start) begin
            opa_r  <= opa;
            opb_r  <= opb;
            iter_r <= 3'd0;
            hi_r   <= 8'h00;
            lo_r   <= opb[7:0];
            cf_r   <= 1'b0;
            if (CLR_ON_START) begin
              result_r <= 16'h0000;
              carry_r  <= 1'b0;
            end
          end
        end
        S_M_ADD: begin
          hi_r <= alu_out;
          cf_r <= alu_cout;
        end
        S_M_SHR: begin
          // The ALU shift inserts a zero; the adder carry is injected here.
          hi_r   <= {cf_r, alu_out[6:0]};
          lo_r   <= {hi_r[0], lo_r[7:1]};
          iter_r <= iter_r + 3'd1;
          if (iter_r == 3'd7) begin
            result_r <= {cf_r, alu_out[6:0], hi_r[0], lo_r[7:1]};
            carry_r  <= 1'b0;
          end
        end
        S_A_LO: begin
          result_r[7:0] <= alu_out;
          cf_r          <= alu_cout;
        end
        S_A_HI: begin
          result_r[15:8] <= alu_out;
          carry_r        <= alu_cout;
        end
        default: begin
          cf_r <= cf_r;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign result  = result_r;
  assign carry   = carry_r;
  assign alu_a   = alu_a_s;
  assign alu_b   = alu_b_s;
  assign alu_sel = alu_sel_s;
  assign alu_cin = alu_cin_s;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with a behavioural 8-bit ALU attached.
module tb_alu_seq_ctrl;

  typedef struct {
    logic [15:0] res;
    logic        car;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [15:0] opa = 16'h0000;
  logic [15:0] opb = 16'h0000;
  logic        busy, done, carry, alu_cin, alu_cout;
  logic [15:0] result;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [2:0]  alu_sel;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   ahi_cyc = -1;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: 000 add with carry, 101 logical shift right, others unused
  always_comb begin
    alu_out  = 8'h00;
    alu_cout = 1'b0;
    case (alu_sel)
      3'b000:  {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
      3'b101:  alu_out = {1'b0, alu_a[7:1]};
      default: alu_out = alu_a ^ alu_b;
    endcase
  end

  alu_seq_ctrl #(.CLR_ON_START(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result), .carry(carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Push the expected outcome of one command and pulse start at the next IDLE edge
  task automatic do_cmd(input logic o, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [16:0] s;
    int          guard = 0;
    @(negedge clk);
    while (busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check("idle_timeout", 32'd0, 32'd1);
    s     = {1'b0, a} + {1'b0, b};
    e.res = o ? s[15:0] : ({8'h00, a[7:0]} * {8'h00, b[7:0]});
    e.car = o ? s[16] : 1'b0;
    e.cyc = cyc + 1 + (o ? 2 : 16);
    if (o) ahi_cyc = cyc + 2;
    sb.push_back(e);
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
    @(negedge clk);
    start = 1'b0;
    op    = 1'($urandom);
    opa   = 16'($urandom);
    opb   = 16'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("clr_on_start", 32'({carry, result}), 32'd0);
  endtask

  task automatic wait_done();
    int guard = 0;
    while (sb.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check("done_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
    check("alu_idle", 32'({alu_a, alu_b, alu_sel, alu_cin}), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  // Per-cycle monitor: ALU op legality, carry-in placement, scoreboard pop on done
  always @(negedge clk) begin
    if (rst_n) begin
      check("alu_sel_legal", 32'(alu_sel == 3'b000 || alu_sel == 3'b101), 32'd1);
      if (alu_cin) check("cin_only_a_hi", 32'(cyc), 32'(ahi_cyc));
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("result", 32'(result), 32'(mon_e.res));
          check("carry", 32'(carry), 32'(mon_e.car));
          check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
          check("busy_in_done", 32'(busy), 32'd1);
        end
      end
    end
  end

  initial begin
    #1;
    check("rst_busy_done", 32'({busy, done, carry}), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_alu", 32'({alu_a, alu_b, alu_sel, alu_cin}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_cmd(1'b0, 16'h000D, 16'h000B);
    wait_done();
    repeat (3) @(negedge clk);
    check("result_hold", 32'(result), 32'h008F);

    do_cmd(1'b0, 16'h00FF, 16'h00FF);
    wait_done();
    do_cmd(1'b0, 16'h0000, 16'h00A5);
    wait_done();
    do_cmd(1'b0, 16'hAB0D, 16'h770B);
    wait_done();
    do_cmd(1'b1, 16'hFFFF, 16'h0001);
    wait_done();
    do_cmd(1'b1, 16'h12F0, 16'h0110);
    wait_done();
    // Back-to-back: second command goes in at the first IDLE edge
    do_cmd(1'b1, 16'h8000, 16'h8000);
    do_cmd(1'b0, 16'h0081, 16'h0003);
    wait_done();

    // start held through a MUL with moving operands; retrigger only once IDLE
    begin
      exp_t e;
      int   c0;
      @(negedge clk);
      c0    = cyc;
      e.res = 16'd63;
      e.car = 1'b0;
      e.cyc = c0 + 17;
      sb.push_back(e);
      start = 1'b1;
      op    = 1'b0;
      opa   = 16'h0007;
      opb   = 16'h0009;
      for (int i = 1; i <= 18; i++) begin
        @(negedge clk);
        if (i < 18) begin
          opa = 16'($urandom);
          opb = 16'($urandom);
        end else begin
          op      = 1'b1;
          opa     = 16'h0003;
          opb     = 16'h0004;
          e.res   = 16'd7;
          e.car   = 1'b0;
          e.cyc   = cyc + 3;
          ahi_cyc = cyc + 2;
          sb.push_back(e);
        end
      end
      @(negedge clk);
      start = 1'b0;
      wait_done();
    end

    // Asynchronous reset in the middle of a MUL
    do_cmd(1'b0, 16'h00C8, 16'h0033);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy_done", 32'({busy, done}), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_alu", 32'({alu_a, alu_b, alu_sel, alu_cin}), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd(1'b0, 16'h0003, 16'h0005);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
